// File: rtl/intr_arbiter_if.sv
// Request/acknowledge bundle between I/O-page devices, the CPU and the interrupt arbiter.
// The arbiter takes the slave modport; the device/CPU side takes the master modport.
interface intr_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_level;
  logic [8*NREQ-1:0] req_vector;
  logic [2:0]        psw_pri;
  logic              cpu_ack;
  logic              interrupt;
  logic [7:0]        interrupt_ipl;
  logic [7:0]        vector;
  logic [NREQ-1:0]   dev_ack;
  logic              busy;

  modport master (
    output req, req_level, req_vector, psw_pri, cpu_ack,
    input  interrupt, interrupt_ipl, vector, dev_ack, busy
  );

  modport slave (
    input  req, req_level, req_vector, psw_pri, cpu_ack,
    output interrupt, interrupt_ipl, vector, dev_ack, busy
  );
endinterface

// File: rtl/intr_arbiter.sv
// Central interrupt arbiter: picks the highest eligible BR level, presents it to the CPU and
// returns a one-cycle dev_ack on cpu_ack. Define INTR_ROUND_ROBIN_EN for round-robin tie-break.
module intr_arbiter #(
  parameter int NREQ = 4
) (
  input logic          clk,
  input logic          reset,
  intr_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ACKED   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [2:0]       level_reg, level_next;
  logic [7:0]       vector_reg, vector_next;
  logic [NREQ-1:0]  mask_reg;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant_onehot;
  logic [2:0]       chan_level  [NREQ];
  logic [7:0]       chan_vector [NREQ];

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [2:0]       win_level;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] search_start;

  // mask_reg keeps the just-acknowledged channel out for one IDLE cycle so it can drop req.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_chan
      assign chan_level[gi]   = bus.req_level[3*gi +: 3];
      assign chan_vector[gi]  = bus.req_vector[8*gi +: 8];
      assign eligible[gi]     = bus.req[gi] && (chan_level[gi] > bus.psw_pri) && !mask_reg[gi];
      assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef INTR_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;

  always_comb begin
    rr_ptr_next = grant_reg + 1'b1;
    if (int'(grant_reg) == NREQ - 1) begin
      rr_ptr_next = '0;
    end
  end

  // Pointer moves only when a grant is actually acknowledged, never on withdrawal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (state_reg == ACKED) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign search_start = rr_ptr_reg;
`else
  assign search_start = '0;
`endif

  // Scan from search_start; strict '>' keeps the first channel met at the winning level.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_level = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'((int'(search_start) + k) % NREQ);
      if (eligible[cand] && (!win_found || (chan_level[cand] > win_level))) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_level = chan_level[cand];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      level_reg  <= '0;
      vector_reg <= '0;
      mask_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      level_reg  <= level_next;
      vector_reg <= vector_next;
      mask_reg   <= (state_reg == ACKED) ? grant_onehot : '0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    level_next  = level_reg;
    vector_next = vector_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next  = PRESENT;
          grant_next  = win_idx;
          level_next  = win_level;
          vector_next = chan_vector[win_idx];
        end
      end
      PRESENT: begin
        // An acknowledge outranks a withdrawal seen in the same cycle.
        if (bus.cpu_ack) begin
          state_next = ACKED;
        end else if (!bus.req[grant_reg] || (bus.psw_pri >= level_reg)) begin
          state_next = IDLE;
        end
      end
      ACKED: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.interrupt     = (state_reg == PRESENT);
  assign bus.interrupt_ipl = (state_reg == PRESENT) ? (8'd1 << level_reg) : 8'd0;
  assign bus.vector        = (state_reg == PRESENT) ? vector_reg : 8'd0;
  assign bus.dev_ack       = (state_reg == ACKED) ? grant_onehot : '0;
  assign bus.busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed bench for intr_arbiter: a table of per-cycle vectors plus hand-written reset and
// tie-break sequences. Tie-break expectations follow INTR_ROUND_ROBIN_EN.
module tb_intr_arbiter;
  localparam int NREQ = 4;
  // Channel levels ch3..ch0 = 7,6,5,4 and vectors ch3..ch0 = 44,30,90,10.
  localparam logic [11:0] LV  = 12'o7654;
  localparam logic [11:0] LV2 = 12'o7657;  // ch0 raised to 7
  localparam logic [11:0] LV3 = 12'o7604;  // ch1 at level 0
  localparam logic [11:0] LVT = 12'o7644;  // ch0 and ch1 tied at level 4
  localparam logic [31:0] VV  = 32'h4430_9010;
  localparam logic [31:0] VV2 = 32'h4430_9077;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  intr_arbiter_if #(.NREQ(NREQ)) bus ();

  intr_arbiter #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] lvl;
    logic [31:0] vec;
    logic [2:0]  psw;
    logic        ack;
    logic [21:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic logic [21:0] pk(input logic intr, input logic [7:0] ipl,
                                     input logic [7:0] vout, input logic [3:0] dack,
                                     input logic busy);
    return {intr, ipl, vout, dack, busy};
  endfunction

  function automatic logic [21:0] obs();
    return {bus.interrupt, bus.interrupt_ipl, bus.vector, bus.dev_ack, bus.busy};
  endfunction

  task automatic add(input logic [3:0] req, input logic [11:0] lvl, input logic [31:0] vec,
                     input logic [2:0] psw, input logic ack, input logic [21:0] exp);
    vec_t v;
    v.req = req; v.lvl = lvl; v.vec = vec; v.psw = psw; v.ack = ack; v.exp = exp;
    vt.push_back(v);
  endtask

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got int=%0b ipl=%h vec=%h dack=%b busy=%0b, expected int=%0b ipl=%h vec=%h dack=%b busy=%0b",
               name, got[21], got[20:13], got[12:5], got[4:1], got[0],
               exp[21], exp[20:13], exp[12:5], exp[4:1], exp[0]);
    end else begin
      $display("ok   %s: int=%0b ipl=%h vec=%h dack=%b busy=%0b",
               name, got[21], got[20:13], got[12:5], got[4:1], got[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [11:0] lvl, input logic [31:0] vec,
                       input logic [2:0] psw, input logic ack);
    bus.req        = req;
    bus.req_level  = lvl;
    bus.req_vector = vec;
    bus.psw_pri    = psw;
    bus.cpu_ack    = ack;
  endtask

  localparam logic [21:0] ZERO = 22'd0;

  initial begin
    int exp_ch;
    logic [7:0] exp_vec;

    // Single request, ack, release
    add(4'b0010, LV, VV, 3'd0, 1'b0, pk(1, 8'h20, 8'h90, 4'b0000, 1));
    add(4'b0010, LV, VV, 3'd0, 1'b1, pk(0, 8'h00, 8'h00, 4'b0010, 1));
    add(4'b0000, LV, VV, 3'd0, 1'b0, ZERO);
    add(4'b0000, LV, VV, 3'd0, 1'b0, ZERO);
    // Priority: ch2 over ch0, then ch0 after ch2 drops; latched values ignore later changes
    add(4'b0101, LV, VV, 3'd0, 1'b0, pk(1, 8'h40, 8'h30, 4'b0000, 1));
    add(4'b0101, LV, VV, 3'd0, 1'b1, pk(0, 8'h00, 8'h00, 4'b0100, 1));
    add(4'b0001, LV, VV, 3'd0, 1'b0, ZERO);
    add(4'b0001, LV, VV, 3'd0, 1'b0, pk(1, 8'h10, 8'h10, 4'b0000, 1));
    add(4'b0001, LV2, VV2, 3'd0, 1'b0, pk(1, 8'h10, 8'h10, 4'b0000, 1));
    add(4'b0001, LV, VV, 3'd0, 1'b1, pk(0, 8'h00, 8'h00, 4'b0001, 1));
    add(4'b0000, LV, VV, 3'd0, 1'b0, ZERO);
    // Masking by psw_pri and withdrawal by raised psw_pri
    add(4'b0001, LV, VV, 3'd4, 1'b0, ZERO);
    add(4'b0001, LV, VV, 3'd4, 1'b0, ZERO);
    add(4'b0001, LV, VV, 3'd3, 1'b0, pk(1, 8'h10, 8'h10, 4'b0000, 1));
    add(4'b0001, LV, VV, 3'd7, 1'b0, ZERO);
    add(4'b0001, LV, VV, 3'd7, 1'b0, ZERO);
    add(4'b0000, LV, VV, 3'd0, 1'b0, ZERO);
    // ch3: drop together with ack (ack wins), then drop alone (no ack)
    add(4'b1000, LV, VV, 3'd0, 1'b0, pk(1, 8'h80, 8'h44, 4'b0000, 1));
    add(4'b0000, LV, VV, 3'd0, 1'b1, pk(0, 8'h00, 8'h00, 4'b1000, 1));
    add(4'b0000, LV, VV, 3'd0, 1'b0, ZERO);
    add(4'b0000, LV, VV, 3'd0, 1'b0, ZERO);
    add(4'b1000, LV, VV, 3'd0, 1'b0, pk(1, 8'h80, 8'h44, 4'b0000, 1));
    add(4'b0000, LV, VV, 3'd0, 1'b0, ZERO);
    add(4'b0000, LV, VV, 3'd0, 1'b1, ZERO);
    // Level-0 request never eligible
    add(4'b0010, LV3, VV, 3'd0, 1'b0, ZERO);
    // Acked channel masked for one IDLE cycle while still requesting
    add(4'b0011, LV, VV, 3'd0, 1'b0, pk(1, 8'h20, 8'h90, 4'b0000, 1));
    add(4'b0011, LV, VV, 3'd0, 1'b1, pk(0, 8'h00, 8'h00, 4'b0010, 1));
    add(4'b0011, LV, VV, 3'd0, 1'b0, ZERO);
    add(4'b0011, LV, VV, 3'd0, 1'b0, pk(1, 8'h10, 8'h10, 4'b0000, 1));
    add(4'b0010, LV, VV, 3'd0, 1'b0, ZERO);
    add(4'b0010, LV, VV, 3'd0, 1'b0, pk(1, 8'h20, 8'h90, 4'b0000, 1));
    add(4'b0000, LV, VV, 3'd0, 1'b0, ZERO);
    // psw_pri filters lower levels out of the contest
    add(4'b0111, LV, VV, 3'd5, 1'b0, pk(1, 8'h40, 8'h30, 4'b0000, 1));
    add(4'b0111, LV, VV, 3'd5, 1'b1, pk(0, 8'h00, 8'h00, 4'b0100, 1));
    add(4'b0000, LV, VV, 3'd0, 1'b0, ZERO);

    drive(4'b0000, LV, VV, 3'd0, 1'b0);
    reset = 1'b1;
    step();
    step();
    check("reset_state", obs(), ZERO);
    reset = 1'b0;
    #1;
    check("after_release", obs(), ZERO);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].req, vt[i].lvl, vt[i].vec, vt[i].psw, vt[i].ack);
      step();
      check($sformatf("vec%0d", i), obs(), vt[i].exp);
    end

    // Reset while PRESENT
    drive(4'b0001, LV, VV, 3'd0, 1'b0);
    step();
    check("rstP_present", obs(), pk(1, 8'h10, 8'h10, 4'b0000, 1));
    bus.cpu_ack = 1'b1;
    #1 reset = 1'b1;
    #1 check("rstP_immediate", obs(), ZERO);
    step();
    check("rstP_held", obs(), ZERO);
    drive(4'b0000, LV, VV, 3'd0, 1'b0);
    reset = 1'b0;
    #1 check("rstP_release", obs(), ZERO);
    step();
    check("rstP_after", obs(), ZERO);

    // Reset while ACKED
    drive(4'b0001, LV, VV, 3'd0, 1'b0);
    step();
    bus.cpu_ack = 1'b1;
    step();
    check("rstA_acked", obs(), pk(0, 8'h00, 8'h00, 4'b0001, 1));
    bus.cpu_ack = 1'b0;
    bus.req = 4'b0000;
    #1 reset = 1'b1;
    #1 check("rstA_immediate", obs(), ZERO);
    step();
    check("rstA_held", obs(), ZERO);
    reset = 1'b0;
    step();
    check("rstA_after", obs(), ZERO);

    // Tie at level 4 between ch0 and ch1; device drops req after each ack
    for (int r = 0; r < 4; r++) begin
`ifdef INTR_ROUND_ROBIN_EN
      exp_ch = r % 2;
`else
      exp_ch = 0;
`endif
      exp_vec = (exp_ch == 0) ? 8'h10 : 8'h90;
      drive(4'b0011, LVT, VV, 3'd0, 1'b0);
      step();
      check($sformatf("tie%0d_grant", r), obs(), pk(1, 8'h10, exp_vec, 4'b0000, 1));
      bus.cpu_ack = 1'b1;
      step();
      check($sformatf("tie%0d_ack", r), obs(), pk(0, 8'h00, 8'h00, 4'(1 << exp_ch), 1));
      drive(4'b0000, LVT, VV, 3'd0, 1'b0);
      step();
      step();
      check($sformatf("tie%0d_idle", r), obs(), ZERO);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/intr_arbiter.md
Name: intr_arbiter

Overview:
- Central interrupt controller for the I/O page. Collects level-sensitive requests from up to NREQ devices (clock, RK, TT, and later additions).
- Each request carries its own bus-request level and vector. The block selects one winner against the current processor priority and presents it to the CPU.
- Completes the CPU acknowledge handshake and returns a one-cycle acknowledge pulse to the winning device.
- Replaces the ad-hoc priority mux and fixed ack_ipl bit mapping in the I/O page decoder.

Parameters:
- NREQ, 4, number of requester channels; channel 0 has the highest tie-break priority.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- req  in  NREQ  level interrupt requests, one per device
- req_level  in  3*NREQ  BR level of channel i at bits [3i+2:3i]
- req_vector  in  8*NREQ  vector of channel i at bits [8i+7:8i]
- psw_pri  in  3  current processor priority, psw[7:5]
- cpu_ack  in  1  one-cycle CPU acknowledge of the presented interrupt
- interrupt  out  1  interrupt pending to CPU
- interrupt_ipl  out  8  one-hot level of the presented interrupt; bit L set
- vector  out  8  vector of the presented interrupt
- dev_ack  out  NREQ  one-cycle acknowledge to the granted device
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset, asynchronous, to state IDLE. All outputs reset to 0: interrupt, interrupt_ipl, vector, dev_ack, busy. The internal grant index and latched level also reset to 0.
- Eligibility: channel i is eligible when req[i] = 1 and req_level(i) > psw_pri (unsigned 3-bit compare). A level-0 request is therefore never eligible.
- Winner selection: the highest req_level among eligible channels. Ties go to the lowest index.
- IDLE:
  - If any channel is eligible, latch the winner's index, level and vector at the clock edge and go to PRESENT.
  - interrupt rises the cycle after req becomes eligible (1-cycle latency).
- PRESENT:
  - interrupt = 1. interrupt_ipl = 1 << latched level. vector = latched vector.
  - All three hold stable; no preemption by a higher request that arrives later.
  - cpu_ack = 1: pulse dev_ack[grant] for exactly one cycle (next cycle) and go to ACKED. interrupt, interrupt_ipl and vector clear to 0 on the same edge.
  - Withdrawal: if req[grant] drops, or psw_pri >= latched level, while cpu_ack = 0, return to IDLE. interrupt clears on that edge and no dev_ack is issued.
  - cpu_ack and withdrawal in the same cycle: cpu_ack wins.
- ACKED:
  - Lasts one cycle. dev_ack[grant] = 1.
  - The granted channel is masked from eligibility during this cycle and the following IDLE cycle, giving the device time to drop req.
  - Go to IDLE.
- cpu_ack outside PRESENT is ignored.
- dev_ack is never asserted for more than one channel or for more than one consecutive cycle.
- busy = 1 in PRESENT and ACKED.
- Reset asserted mid-handshake (PRESENT or ACKED) aborts it immediately: no dev_ack pulse is issued.
- req_level and req_vector are sampled only at the IDLE -> PRESENT edge. Later changes do not affect the presented values.

Optional Feature:
- INTR_ROUND_ROBIN_EN
  - Defined: ties among eligible channels at the same level are broken round-robin. Search starts at the index after the last acknowledged channel, wrapping NREQ-1 -> 0.
  - The round-robin pointer resets to 0 and advances only on ACKED, not on withdrawal.
  - Not defined: fixed lowest-index tie-break. No pointer register is built.

Test Plan:
- Single request: req[1] = 1, level 5, vector 0220, psw_pri 0.
  -> interrupt = 1 next cycle, interrupt_ipl = 8'h20, vector = 0220.
  -> cpu_ack gives dev_ack = 4'b0010 for one cycle; interrupt = 0.
- Priority: req[0] at level 4 and req[2] at level 6 together, psw_pri 0.
  -> ch2 presented, interrupt_ipl = 8'h40.
  -> After ack and the device dropping req, ch0 presented with interrupt_ipl = 8'h10.
- Masking: req[0] at level 4, psw_pri 4.
  -> interrupt stays 0.
  -> psw_pri -> 3 gives interrupt = 1 next cycle.
  -> psw_pri -> 7 while PRESENT returns to IDLE with no dev_ack.
- Withdrawal vs ack: req[3] drops in the same cycle cpu_ack = 1.
  -> dev_ack[3] pulses once (ack wins).
  -> req[3] dropping alone in PRESENT -> interrupt = 0 next cycle, dev_ack stays 0.
- Reset: assert reset in PRESENT and in ACKED.
  -> All outputs 0 immediately, no dev_ack pulse, state IDLE after release.
- Tie (INTR_ROUND_ROBIN_EN): req[0] and req[1] both held at level 4, repeatedly acked.
  -> Grants alternate 0,1,0,1.
  -> Without the macro, grants are 0,0,0,0.
